// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS9 (x^9 + x^5 + 1) serial checker.
// SEARCH shifts received bits into a 9-bit history and counts consecutive
// predictions that come true. LOCKED free-runs a local generator and counts
// compared bits and errors. A windowed error density drops lock.
module prbs_checker #(
  parameter int LOCK_THRESH = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_prbSeq,
  input  logic             i_clrCnt,
  output logic             o_lock,
  output logic             o_error,
  output logic [CNT_W-1:0] o_bitCount,
  output logic [CNT_W-1:0] o_errCount
);

  localparam int MC_W = $clog2(LOCK_THRESH + 1);
  localparam int WB_W = $clog2(WINDOW + 1);
  localparam int WE_W = $clog2(UNLOCK_ERRS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [8:0]      r_q, r_d;        // r[0] newest bit
  logic [3:0]      fill_q, fill_d;
  logic [MC_W-1:0] match_q, match_d;
  logic [WB_W-1:0] wbits_q, wbits_d;
  logic [WE_W-1:0] werr_q, werr_d;
  logic            exp_bit, mism;
  logic            err_d, cnt_bit, cnt_err;

  // Next-state: history shifting, lock search, window tracking and unlock.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fill_d  = fill_q;
    match_d = match_q;
    wbits_d = wbits_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    cnt_bit = 1'b0;
    cnt_err = 1'b0;
    exp_bit = r_q[8] ^ r_q[4];
    mism    = i_prbSeq ^ exp_bit;
    if (i_enable) begin
      case (state_q)
        SEARCH: begin
          r_d = {r_q[7:0], i_prbSeq};
          if (fill_q != 4'd9) begin
            fill_d = fill_q + 4'd1;
          end else if (mism || (r_q == 9'd0)) begin
            // all-zero history predicts zeros forever; never lock on it
            match_d = '0;
          end else if (match_q == MC_W'(LOCK_THRESH - 1)) begin
            state_d = LOCKED;
            match_d = '0;
          end else begin
            match_d = match_q + MC_W'(1);
          end
        end
        LOCKED: begin
          // feed back the prediction so one line error is counted once
          r_d     = {r_q[7:0], exp_bit};
          cnt_bit = 1'b1;
          cnt_err = mism;
          err_d   = mism;
          if (mism && (werr_q == WE_W'(UNLOCK_ERRS - 1))) begin
            // unlock beats window rollover; history is refilled by SEARCH
            state_d = SEARCH;
            fill_d  = 4'd0;
            match_d = '0;
            wbits_d = '0;
            werr_d  = '0;
          end else if (wbits_q == WB_W'(WINDOW - 1)) begin
            wbits_d = '0;
            werr_d  = '0;
          end else begin
            wbits_d = wbits_q + WB_W'(1);
            werr_d  = werr_q + WE_W'(mism);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // State and status registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= SEARCH;
      r_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      wbits_q <= '0;
      werr_q  <= '0;
      o_lock  <= 1'b0;
      o_error <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      wbits_q <= wbits_d;
      werr_q  <= werr_d;
      o_lock  <= (state_d == LOCKED);
      o_error <= err_d;
    end
  end

  // Saturating BER counters; a clear overrides a bit counted on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clrCnt) begin
      o_bitCount <= '0;
      o_errCount <= '0;
    end else begin
      if (cnt_bit && (o_bitCount != CNT_MAX)) o_bitCount <= o_bitCount + CNT_W'(1);
      if (cnt_err && (o_errCount != CNT_MAX)) o_errCount <= o_errCount + CNT_W'(1);
    end
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS9 checker that sits directly downstream of the `lfsr` generator and consumes its `o_prbSeq` bit stream, one bit per enabled clock. It self-synchronises to the x^9 + x^5 + 1 sequence without needing the generator seed. Once locked, it counts compared bits and bit errors for bit-error-rate measurement. It drops lock and re-searches when the error density in a window exceeds a threshold.

## Interface
- `LOCK_THRESH`, default 16: consecutive matching bits required to declare lock.
- `WINDOW`, default 64: compared bits per error-density window while locked.
- `UNLOCK_ERRS`, default 8: errors within one window that force loss of lock; must be ≤ `WINDOW`.
- `CNT_W`, default 32: width of the bit and error counters.
- `i_clk`, in, 1: single clock, rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_enable`, in, 1: sample qualifier; the checker acts only on cycles with `i_enable` = 1.
- `i_prbSeq`, in, 1: received PRBS bit.
- `i_clrCnt`, in, 1: synchronous clear of `o_bitCount` and `o_errCount`; lock state is unaffected.
- `o_lock`, out, 1: checker is in LOCKED.
- `o_error`, out, 1: one-cycle pulse marking a mismatched bit while LOCKED.
- `o_bitCount`, out, `CNT_W`: bits compared while LOCKED; saturating.
- `o_errCount`, out, `CNT_W`: mismatches while LOCKED; saturating.

## Operation
- 9-bit history register `r`, with `r[0]` holding the newest bit. The expected next bit is `r[8] ^ r[4]` (recurrence b[n] = b[n-9] ^ b[n-5]).
- Cycles with `i_enable` = 0 change no state, and `o_error` is 0.
- **SEARCH** state:
  - Received bits shift into `r`.
  - A fill counter counts up to 9; no comparison happens until `r` is full.
  - Once full, each bit is compared with the expected bit.
  - A match increments `match_cnt`. A mismatch, or `r` == 0 (the all-zero lockup guard), resets `match_cnt` to 0.
  - When `match_cnt` reaches `LOCK_THRESH`, the state goes to LOCKED.
- **LOCKED** state:
  - The expected bit, not the received bit, shifts into `r`. The local generator free-runs, so one line error counts exactly once.
  - Each bit: `o_bitCount` += 1.
  - On mismatch: `o_errCount` += 1, `o_error` = 1, and `win_err` += 1.
- **Window**: `win_bits` counts compared bits in LOCKED. On the `WINDOW`-th bit, both `win_bits` and `win_err` reset to 0.
- **Unlock**: when `win_err` reaches `UNLOCK_ERRS`, the state goes to SEARCH. On this transition the fill counter, `match_cnt`, `win_bits` and `win_err` clear, and `r` is refilled from the input.
- **Counters**: saturate at 2^`CNT_W` − 1 and hold; they never wrap.
- **Simultaneous events**:
  - `i_clrCnt` with a counted bit: clear wins, and both counters become 0.
  - Unlock threshold reached on the last bit of a window: unlock wins.
  - The mismatch that triggers unlock is still counted in `o_errCount` and pulses `o_error`.
- **Reset**: `i_reset` at any time, including mid-lock, returns to SEARCH. `r`, all internal counters and all outputs go to 0.

## Timing
- All outputs are registered and update on the rising edge that samples the bit.
- Reset values: `o_lock` = 0, `o_error` = 0, `o_bitCount` = 0, `o_errCount` = 0.
- Lock latency from reset with a clean stream: 9 fill bits plus `LOCK_THRESH` matches. `o_lock` rises on the edge sampling the 25th enabled bit (defaults).
- Unlock: `o_lock` falls on the edge sampling the bit that makes `win_err` = `UNLOCK_ERRS`.
- `o_error` is high for exactly one cycle per errored bit.
- Counters reflect a bit on the same edge as its `o_error`.

## Test plan
- **Clean lock**: `lfsr` (SEED 0x1FE) feeds `i_prbSeq`, with `i_enable` = 1. Required:
  - `o_lock` = 1 after 25 enabled bits.
  - After 1000 further bits: `o_bitCount` = 1000, `o_errCount` = 0, and `o_error` never asserted.
- **Single error**: invert one bit after lock. Required:
  - `o_error` pulses once.
  - `o_errCount` = 1.
  - `o_lock` stays 1.
- **Stuck inputs**:
  - `i_prbSeq` held at 0 from reset for 200 cycles: `o_lock` stays 0 (all-zero guard).
  - `i_prbSeq` held at 1 for 200 cycles: `o_lock` stays 0.
- **Loss of lock**: after lock, switch the input to constant 0. Required:
  - `o_lock` falls once `win_err` = 8 within one 64-bit window.
  - Restoring the `lfsr` stream relocks after 25 bits.
- **Enable gating and saturation**:
  - Toggle `i_enable` 1/0 every cycle: lock occurs after 25 enabled cycles (about 50 clocks).
  - With `CNT_W` = 4, inject 20 errors spaced more than `WINDOW` apart: `o_errCount` holds at 15.
- **Clear and reset**:
  - `i_clrCnt` coincident with an error: both counters read 0 the next cycle.
  - `i_reset` mid-lock: all outputs read 0 on the following edge, and the checker relocks after 25 bits.
